// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Optional hold timeout is enabled by defining ARB_HOLD_TIMEOUT_EN.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   // Bit j of the result is v[(j+k) mod 4], so the requester after k-1 lands at bit 0
   function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] v,
                                                   input logic [IDX_W-1:0] k);
      logic [2*N_REQ-1:0] t;
      t = {v, v} >> k;
      return t[N_REQ-1:0];
   endfunction

endpackage

// File: rtl/prio_enc_4x2.sv
// Combinational 4->2 priority encoder, lowest index wins; o_vld flags any input set.
module prio_enc_4x2
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_vld
);

   always_comb begin
      o_idx = '0;
      o_vld = 1'b1;
      casez (i_vec)
         4'b???1: o_idx = 2'd0;
         4'b??10: o_idx = 2'd1;
         4'b?100: o_idx = 2'd2;
         4'b1000: o_idx = 2'd3;
         default: begin
            o_idx = 2'd0;
            o_vld = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters; grant held until owner releases.
// Define ARB_HOLD_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
//
//   state | meaning
//   IDLE  | no grant active; arbitrate among req on the next edge
//   BUSY  | one requester owns the resource until it drops its req
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   if ((MAX_HOLD < 2) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_bad_cfg
      $error("rr_arbiter_4: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
   end

   arb_state_t       r_state;
   logic [N_REQ-1:0] r_gnt;
   logic [IDX_W-1:0] r_gnt_idx;
   logic [IDX_W-1:0] r_last_idx;

   logic [IDX_W-1:0] w_start;
   logic [N_REQ-1:0] w_rot;
   logic [IDX_W-1:0] w_enc_idx;
   logic             w_enc_vld;
   logic [IDX_W-1:0] w_win;
   logic             w_owner_req;

   // Search begins one past the last winner; 2-bit overflow gives the mod-4 wrap
   assign w_start     = r_last_idx + 2'd1;
   assign w_rot       = rot_right(req, w_start);
   assign w_win       = w_enc_idx + w_start;
   assign w_owner_req = req[r_gnt_idx];

   prio_enc_4x2 u_prio_enc (
      .i_vec (w_rot),
      .o_idx (w_enc_idx),
      .o_vld (w_enc_vld)
   );

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

   logic [CNT_W-1:0] r_hold_cnt;
   logic             r_timeout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gnt_idx  <= '0;
         r_last_idx <= 2'd3;
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_enc_vld) begin
                  r_state    <= BUSY;
                  r_gnt      <= N_REQ'(1) << w_win;
                  r_gnt_idx  <= w_win;
                  r_last_idx <= w_win;
                  r_hold_cnt <= '0;
               end
            end
            BUSY: begin
               if (!w_owner_req) begin
                  r_state   <= IDLE;
                  r_gnt     <= '0;
                  r_gnt_idx <= '0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  // last_idx keeps the revoked owner so it drops to lowest priority
                  r_state   <= IDLE;
                  r_gnt     <= '0;
                  r_gnt_idx <= '0;
                  r_timeout <= 1'b1;
               end else if (r_hold_cnt != HOLD_SAT) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign timeout = r_timeout;
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gnt_idx  <= '0;
         r_last_idx <= 2'd3;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_enc_vld) begin
                  r_state    <= BUSY;
                  r_gnt      <= N_REQ'(1) << w_win;
                  r_gnt_idx  <= w_win;
                  r_last_idx <= w_win;
               end
            end
            BUSY: begin
               if (!w_owner_req) begin
                  r_state   <= IDLE;
                  r_gnt     <= '0;
                  r_gnt_idx <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign timeout = 1'b0;
`endif

   assign gnt       = r_gnt;
   assign gnt_idx   = r_gnt_idx;
   assign gnt_valid = |r_gnt;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus random traffic vs. a behavioural model.
module tb_rr_arbiter_4;

   localparam int TB_MAX_HOLD = 4;
   localparam int TB_CNT_W    = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   // Behavioural model: owner number (-1 = none), last winner, grant age
   int m_owner = -1;
   int m_last  = 3;
   int m_hold  = 0;
   bit m_to    = 1'b0;

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   rr_arbiter_4 #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(TB_CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic [3:0] r, input logic rb);
      m_to = 1'b0;
      if (!rb) begin
         m_owner = -1;
         m_last  = 3;
         m_hold  = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (r[c] && m_owner < 0) begin
               m_owner = c;
               m_last  = c;
               m_hold  = 0;
            end
         end
      end else if (!r[m_owner]) begin
         m_owner = -1;
      end else if (TO_EN && m_hold == TB_MAX_HOLD - 1) begin
         m_owner = -1;
         m_to    = 1'b1;
      end else begin
         m_hold++;
      end
   endtask

   task automatic check_model();
      logic [3:0] e_gnt;
      logic [3:0] e_idx;
      e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      e_idx = (m_owner < 0) ? 4'd0 : 4'(m_owner);
      chk("gnt",       gnt, e_gnt);
      chk("gnt_idx",   {2'b00, gnt_idx}, e_idx);
      chk("gnt_valid", {3'b000, gnt_valid}, {3'b000, (m_owner >= 0)});
      chk("timeout",   {3'b000, timeout}, {3'b000, m_to});
   endtask

   task automatic step(input logic [3:0] r, input logic rb);
      @(negedge clk);
      req   = r;
      rst_n = rb;
      @(posedge clk);
      model_update(r, rb);
      #1;
      check_model();
   endtask

   initial begin
      logic [3:0] rr;
      int         seen;

      // 1: reset held with all requests asserted
      step(4'b1111, 1'b0);
      chk("rst_gnt_c1", gnt, 4'b0000);
      step(4'b1111, 1'b0);
      chk("rst_gnt_c2", gnt, 4'b0000);
      chk("rst_idx", {2'b00, gnt_idx}, 4'd0);

      // 2: single request, 1-cycle latency, release
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b1);
      chk("single_gnt", gnt, 4'b0100);
      chk("single_idx", {2'b00, gnt_idx}, 4'd2);
      step(4'b0000, 1'b1);
      chk("single_rel", gnt, 4'b0000);

      // 3: rotation 0,1,2,3,0 with idle cycle between grants
      step(4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b1);
         chk("rr_order", gnt, 4'b0001 << (i % 4));
         step(4'b1111 & ~(4'b0001 << (i % 4)), 1'b1);
         chk("rr_idle", gnt, 4'b0000);
      end

      // 4: owner 1 holds, req[3] arrives mid-grant
      step(4'b0000, 1'b0);
      step(4'b0010, 1'b1);
      step(4'b1010, 1'b1);
      chk("hold_1a", gnt, 4'b0010);
      step(4'b1010, 1'b1);
      chk("hold_1b", gnt, 4'b0010);
      step(4'b1000, 1'b1);
      chk("hold_rel", gnt, 4'b0000);
      step(4'b1000, 1'b1);
      chk("hold_next", gnt, 4'b1000);

      // 5: hold timeout (only meaningful with the feature built in)
      step(4'b0000, 1'b0);
      step(4'b0011, 1'b1);
      chk("to_first", gnt, 4'b0001);
      for (int i = 1; i < TB_MAX_HOLD; i++) step(4'b0011, 1'b1);
      chk("to_last_held", gnt, 4'b0001);
      step(4'b0011, 1'b1);
`ifdef ARB_HOLD_TIMEOUT_EN
      chk("to_revoked", gnt, 4'b0000);
      chk("to_pulse", {3'b000, timeout}, 4'd1);
      step(4'b0011, 1'b1);
      chk("to_next", gnt, 4'b0010);
      chk("to_pulse_end", {3'b000, timeout}, 4'd0);
`else
      chk("no_to_held", gnt, 4'b0001);
      chk("no_to_pulse", {3'b000, timeout}, 4'd0);
`endif

      // 6: reset during a grant to requester 2
      step(4'b0000, 1'b0);
      step(4'b0100, 1'b1);
      chk("rst_mid_pre", gnt, 4'b0100);
      step(4'b0100, 1'b0);
      chk("rst_mid_drop", gnt, 4'b0000);
      step(4'b0101, 1'b1);
      chk("rst_mid_ptr", gnt, 4'b0001);

      // Random traffic; the owner tends to keep its request for a while
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         rr = 4'($urandom_range(0, 15));
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) rr[m_owner] = 1'b1;
         step(rr, ($urandom_range(0, 49) != 0));
         if (gnt_valid) seen++;
      end
      total++;
      assert (seen > 50) else begin
         bad++;
         $error("FAIL rand_activity observed=%0d expected=>50", seen);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
